arbiter_merge_leaf: RTL and testbench
=====================================

ARBITER_MERGE_LEAF -- requirements
Module: arbiter_merge_leaf

Interface
REQ-001 SHALL have parameter W, default 9: packet width; bits [W-1:W-4] are the 4-bit address field, the rest payload.
REQ-002 SHALL have parameter CNT_W, default 16: width of the per-input grant counters.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have ports in0_data / in1_data  input  W: packets from the two decoder outputs (Out0 and Out1 side).
REQ-006 SHALL have ports in0_valid / in1_valid  input  1: packet present on in0 / in1.
REQ-007 SHALL have ports in0_ready / in1_ready  output  1: packet accepted when valid and ready are both high at a clock edge.
REQ-008 SHALL have port out_data  output  W: merged packet.
REQ-009 SHALL have port out_src  output  1: source of out_data (0 = in0, 1 = in1), same encoding as the decoder select.
REQ-010 SHALL have port out_valid  output  1: out_data and out_src valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts when out_valid and out_ready are both high.
REQ-012 SHALL have ports cnt0 / cnt1  output  CNT_W: number of packets granted from in0 / in1.

Function
REQ-013 SHALL hold one output register (data, src, valid); out_data, out_src, out_valid driven directly from it, no combinational path from inputs.
REQ-014 SHALL treat the register as able to load when it is empty or out_ready is high (load_ok).
REQ-015 SHALL grant at most one input per cycle; in0_ready/in1_ready high only for the granted input, and only when load_ok.
REQ-016 Grant rules: one requester -> grant it; both requesting -> grant input named by the priority pointer prio; none -> no grant.
REQ-017 SHALL update prio only on a contested grant (both valid and load_ok): prio becomes the input not granted. Uncontested grants leave prio unchanged.
REQ-018 On a grant, the register SHALL load the granted data, set src to the granted index and set valid, at the same edge.
REQ-019 When out_valid and out_ready are high and no grant occurs, valid SHALL clear at that edge.
REQ-020 Latency SHALL be one cycle from input acceptance to out_valid; sustained throughput one packet per cycle when out_ready stays high.
REQ-021 While out_valid is high and out_ready low, out_data and out_src SHALL remain stable and both inputs SHALL see ready low.
REQ-022 in*_ready SHALL depend only on in*_valid, out_ready, register valid and prio (ready may depend on valid; the arbitration needs this).
REQ-023 cnt0/cnt1 SHALL increment by one on each grant of that input and saturate at 2^CNT_W-1, never wrapping.
REQ-024 The block SHALL not inspect or alter packet contents; out_data equals the accepted in*_data bit for bit.

Reset
REQ-025 When rst_n is low, asynchronously: out_valid=0, out_data=0, out_src=0, prio=0 (in0 favoured), cnt0=cnt1=0, in0_ready=in1_ready=0.
REQ-026 A packet held in the register when reset asserts SHALL be dropped; no grant occurs in the cycle rst_n deasserts; first grant is possible on the first edge with rst_n high.

Verification
REQ-027 After reset, in0_valid=1 data 0x0A5, out_ready=1 -> in0_ready=1; next cycle out_data=0x0A5, out_src=0, out_valid=1, cnt0=1.
REQ-028 Both valid continuously, out_ready=1, from reset -> grant order in0,in1,in0,in1...; out_src toggles 0,1,0,1; cnt0 and cnt1 differ by at most 1.
REQ-029 out_valid=1 with out_ready=0 for 5 cycles, both inputs valid -> in0_ready=in1_ready=0, out_data/out_src unchanged, counters unchanged; on out_ready=1 the next grant loads in the same edge as the drain (no bubble).
REQ-030 Only in1 valid for 3 packets, then both valid -> out_src 1,1,1 then grant in0 (prio still 0), then in1.
REQ-031 With CNT_W=2, grant in0 five times -> cnt0 reads 1,2,3,3,3.
REQ-032 Assert rst_n low while out_valid=1 and out_ready=0 -> out_valid drops immediately, without a clock edge; after release, cnt0=cnt1=0 and prio favours in0.

Source files
------------

// File: rtl/arbiter_merge_leaf.sv
// Two-input round-robin merge: arbitrates two valid/ready packet streams into one
// registered output stage, tagging each packet with its source and counting grants.
module arbiter_merge_leaf #(
  parameter int W     = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [W-1:0]     in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [W-1:0]     out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [W-1:0]     r_data;
  logic             r_src;
  logic             r_valid;
  logic             r_prio;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_load_ok;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_contested;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // rst_n gates the grants so nothing is accepted while reset is held.
  always_comb begin
    w_load_ok   = ~r_valid | out_ready;
    w_grant0    = rst_n & w_load_ok & in0_valid & (~in1_valid | ~r_prio);
    w_grant1    = rst_n & w_load_ok & in1_valid & (~in0_valid | r_prio);
    w_contested = rst_n & w_load_ok & in0_valid & in1_valid;
  end

  assign in0_ready = w_grant0;
  assign in1_ready = w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_src   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_grant0) begin
      r_data  <= in0_data;
      r_src   <= 1'b0;
      r_valid <= 1'b1;
    end else if (w_grant1) begin
      r_data  <= in1_data;
      r_src   <= 1'b1;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Priority only moves on a contested grant: it points at the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_contested) begin
      r_prio <= w_grant0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant0 && (r_cnt0 != CNT_MAX)) r_cnt0 <= r_cnt0 + CNT_ONE;
      if (w_grant1 && (r_cnt1 != CNT_MAX)) r_cnt1 <= r_cnt1 + CNT_ONE;
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

endmodule

// File: tb/tb_arbiter_merge_leaf.sv
// Directed bench for arbiter_merge_leaf; a second instance with CNT_W=2 shares
// all inputs and is used for the saturation scenario.
module tb_arbiter_merge_leaf;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in0_data, in1_data;
  logic         in0_valid, in1_valid, out_ready;
  logic         in0_ready, in1_ready, out_src, out_valid;
  logic [W-1:0] out_data;
  logic [15:0]  cnt0, cnt1;
  logic         s_in0_ready, s_in1_ready, s_out_src, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_cnt0, s_cnt1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  arbiter_merge_leaf #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  arbiter_merge_leaf #(.W(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(s_in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(s_in1_ready),
    .out_data(s_out_data), .out_src(s_out_src), .out_valid(s_out_valid),
    .out_ready(out_ready), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    in0_data = 9'h1AA; in1_data = 9'h055;
    @(posedge clk); #2;
    total++;
    if (out_valid !== 1'b0 || out_data !== 9'h000 || out_src !== 1'b0) begin
      $display("FAIL reset_out: valid=%b data=%h src=%b, required 0 000 0", out_valid, out_data, out_src);
    end else passed++;
    total++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d, required 0 0", cnt0, cnt1);
    end else passed++;
    total++;
    if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      $display("FAIL reset_ready: in0_ready=%b in1_ready=%b, required 0 0", in0_ready, in1_ready);
    end else passed++;
    $display("reset: valid=%b cnt0=%0d cnt1=%0d", out_valid, cnt0, cnt1);
  endtask

  task automatic test_single();
    do_reset();
    in0_valid = 1'b1; in0_data = 9'h0A5; out_ready = 1'b1;
    #1;
    total++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      $display("FAIL single_ready: in0_ready=%b in1_ready=%b, required 1 0", in0_ready, in1_ready);
    end else passed++;
    @(posedge clk); #1;
    in0_valid = 1'b0;
    total++;
    if (out_data !== 9'h0A5 || out_src !== 1'b0 || out_valid !== 1'b1 || cnt0 !== 16'd1) begin
      $display("FAIL single_out: data=%h src=%b valid=%b cnt0=%0d, required 0a5 0 1 1",
               out_data, out_src, out_valid, cnt0);
    end else passed++;
    $display("single: data=%h src=%b cnt0=%0d", out_data, out_src, cnt0);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_drain: valid=%b, required 0", out_valid);
    end else passed++;
  endtask

  task automatic test_alternate();
    do_reset();
    in0_valid = 1'b1; in0_data = 9'h011;
    in1_valid = 1'b1; in1_data = 9'h122;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic         exp_src;
      logic [W-1:0] exp_data;
      logic [15:0]  exp_c0, exp_c1;
      @(posedge clk); #1;
      exp_src  = (i % 2 == 1);
      exp_data = exp_src ? 9'h122 : 9'h011;
      exp_c0   = 16'(i / 2 + 1);
      exp_c1   = 16'((i + 1) / 2);
      total++;
      if (out_src !== exp_src || out_data !== exp_data || out_valid !== 1'b1) begin
        $display("FAIL alt_out[%0d]: src=%b data=%h valid=%b, required %b %h 1",
                 i, out_src, out_data, out_valid, exp_src, exp_data);
      end else passed++;
      total++;
      if (cnt0 !== exp_c0 || cnt1 !== exp_c1) begin
        $display("FAIL alt_cnt[%0d]: cnt0=%0d cnt1=%0d, required %0d %0d", i, cnt0, cnt1, exp_c0, exp_c1);
      end else passed++;
      $display("alt[%0d]: src=%b data=%h cnt0=%0d cnt1=%0d", i, out_src, out_data, cnt0, cnt1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    in0_valid = 1'b1; in0_data = 9'h155; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in0_data = 9'h0B6;
    in1_valid = 1'b1; in1_data = 9'h1C7;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        $display("FAIL stall_ready[%0d]: in0_ready=%b in1_ready=%b, required 0 0", i, in0_ready, in1_ready);
      end else passed++;
      @(posedge clk); #1;
      total++;
      if (out_data !== 9'h155 || out_src !== 1'b0 || out_valid !== 1'b1 || cnt0 !== 16'd1 || cnt1 !== 16'd0) begin
        $display("FAIL stall_hold[%0d]: data=%h src=%b valid=%b cnt0=%0d cnt1=%0d, required 155 0 1 1 0",
                 i, out_data, out_src, out_valid, cnt0, cnt1);
      end else passed++;
      $display("stall[%0d]: data=%h src=%b", i, out_data, out_src);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      $display("FAIL stall_release_ready: in0_ready=%b in1_ready=%b, required 1 0", in0_ready, in1_ready);
    end else passed++;
    @(posedge clk); #1;
    total++;
    if (out_data !== 9'h0B6 || out_src !== 1'b0 || out_valid !== 1'b1 || cnt0 !== 16'd2) begin
      $display("FAIL stall_nobubble: data=%h src=%b valid=%b cnt0=%0d, required 0b6 0 1 2",
               out_data, out_src, out_valid, cnt0);
    end else passed++;
    @(posedge clk); #1;
    total++;
    if (out_data !== 9'h1C7 || out_src !== 1'b1 || cnt1 !== 16'd1) begin
      $display("FAIL stall_next: data=%h src=%b cnt1=%0d, required 1c7 1 1", out_data, out_src, cnt1);
    end else passed++;
  endtask

  task automatic test_in1_only();
    do_reset();
    in1_valid = 1'b1; in1_data = 9'h0F1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_src !== 1'b1 || out_data !== 9'h0F1 || cnt1 !== 16'(i + 1)) begin
        $display("FAIL in1only[%0d]: src=%b data=%h cnt1=%0d, required 1 0f1 %0d",
                 i, out_src, out_data, cnt1, i + 1);
      end else passed++;
      $display("in1only[%0d]: src=%b cnt1=%0d", i, out_src, cnt1);
    end
    in0_valid = 1'b1; in0_data = 9'h033;
    @(posedge clk); #1;
    total++;
    if (out_src !== 1'b0 || out_data !== 9'h033) begin
      $display("FAIL in1only_then0: src=%b data=%h, required 0 033", out_src, out_data);
    end else passed++;
    @(posedge clk); #1;
    total++;
    if (out_src !== 1'b1 || out_data !== 9'h0F1) begin
      $display("FAIL in1only_then1: src=%b data=%h, required 1 0f1", out_src, out_data);
    end else passed++;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    in0_valid = 1'b1; in0_data = 9'h07E; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (s_cnt0 !== exp_cnt[i]) begin
        $display("FAIL sat_cnt0[%0d]: cnt0=%0d, required %0d", i, s_cnt0, exp_cnt[i]);
      end else passed++;
      $display("sat[%0d]: cnt0=%0d", i, s_cnt0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in0_valid = 1'b1; in0_data = 9'h0C3;
    in1_valid = 1'b1; in1_data = 9'h13C;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      $display("FAIL arst_pre: valid=%b, required 1", out_valid);
    end else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 9'h000 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
      $display("FAIL arst_drop: valid=%b data=%h rdy=%b%b, required 0 000 00",
               out_valid, out_data, in0_ready, in1_ready);
    end else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    total++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      $display("FAIL arst_cnt: cnt0=%0d cnt1=%0d, required 0 0", cnt0, cnt1);
    end else passed++;
    total++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      $display("FAIL arst_prio: in0_ready=%b in1_ready=%b, required 1 0", in0_ready, in1_ready);
    end else passed++;
    @(posedge clk); #1;
    total++;
    if (out_src !== 1'b0 || out_data !== 9'h0C3 || cnt0 !== 16'd1 || cnt1 !== 16'd0) begin
      $display("FAIL arst_first: src=%b data=%h cnt0=%0d cnt1=%0d, required 0 0c3 1 0",
               out_src, out_data, cnt0, cnt1);
    end else passed++;
    $display("arst: src=%b data=%h cnt0=%0d", out_src, out_data, cnt0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_in1_only();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
